// File: rtl/lal_state_reg_if.sv
// Handshake and data bundle for the lal state stage.
// Master is the producer side; slave is the state register.
interface lal_state_reg_if #(
    parameter int WIDTH = 9,
    parameter int CMP_W = 4
);
    logic             pclr;
    logic             pcnt_en;
    logic             pload_valid;
    logic             pload_ready;
    logic [WIDTH-1:0] pload_data;
    logic [CMP_W-1:0] pcmp_a;
    logic [CMP_W-1:0] pcmp_b;
    logic [WIDTH-1:0] pcnt_q;
    logic             ptc;
    logic             pdone;
    logic             pcmp_ge;
    logic             pcmp_eq;

    modport master (
        output pclr, pcnt_en, pload_valid, pload_data,
        output pcmp_a, pcmp_b,
        input  pload_ready, pcnt_q, ptc, pdone,
        input  pcmp_ge, pcmp_eq
    );

    modport slave (
        input  pclr, pcnt_en, pload_valid, pload_data,
        input  pcmp_a, pcmp_b,
        output pload_ready, pcnt_q, ptc, pdone,
        output pcmp_ge, pcmp_eq
    );
endinterface

// File: rtl/lal_state_reg.sv
// Registered count/state stage for lal: saturating counter with
// load handshake, terminal flag, done pulse and a registered compare.
module lal_state_reg #(
    parameter int WIDTH = 9,
    parameter int CMP_W = 4
) (
    input  logic         pclk,
    input  logic         prst_n,
    lal_state_reg_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             ge_q, ge_d;
    logic             eq_q, eq_d;
    logic [WIDTH-1:0] cnt_inc;
    logic             load_ready;
    logic             load_acc;

    assign load_ready = (state_q != RUN) & ~bus.pclr;
    assign load_acc   = bus.pload_valid & load_ready;
    assign cnt_inc    = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = tc_q;
        done_d  = 1'b0;
        if (bus.pclr) begin
            state_d = IDLE;
            cnt_d   = '0;
            tc_d    = 1'b0;
        end else if (load_acc) begin
            state_d = IDLE;
            cnt_d   = bus.pload_data;
            tc_d    = &bus.pload_data;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.pcnt_en) begin
                        // Already saturated: enter DONE without wrapping
                        if (&cnt_q) begin
                            state_d = DONE;
                            tc_d    = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                            if (&cnt_inc) begin
                                state_d = DONE;
                                tc_d    = 1'b1;
                                done_d  = 1'b1;
                            end else begin
                                state_d = RUN;
                            end
                        end
                    end
                end
                RUN: begin
                    if (bus.pcnt_en) begin
                        cnt_d = cnt_inc;
                        if (&cnt_inc) begin
                            state_d = DONE;
                            tc_d    = 1'b1;
                            done_d  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    cnt_d = '1;
                    tc_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ge_d = (bus.pcmp_a >= bus.pcmp_b);
        eq_d = (bus.pcmp_a == bus.pcmp_b);
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    // Comparator ignores pclr; only reset clears it
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            ge_q <= 1'b0;
            eq_q <= 1'b0;
        end else begin
            ge_q <= ge_d;
            eq_q <= eq_d;
        end
    end

    assign bus.pload_ready = load_ready;
    assign bus.pcnt_q      = cnt_q;
    assign bus.ptc         = tc_q;
    assign bus.pdone       = done_q;
    assign bus.pcmp_ge     = ge_q;
    assign bus.pcmp_eq     = eq_q;
endmodule
